pc_fetch: RTL and testbench

Program-counter register and instruction-fetch sequencer for the MIPS core. Holds the current word-address PC and fetches the instruction at that address over a request/response instruction-memory port. It presents the instruction and its address to decode and to the next-PC logic. It loads the next-PC logic's `next_addr` output only once decode has consumed the current instruction.

---
 rtl/pc_fetch_pkg.sv | 20 ++
 rtl/pc_fetch_perf.sv | 30 +++
 rtl/pc_fetch.sv | 109 ++++++++++
 tb/tb_pc_fetch.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Purpose : shared types and constants for the program-counter / fetch block.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package pc_fetch_pkg;

  localparam int ADDR_W  = 30;  // word address width, PC[31:2]
  localparam int INSTR_W = 32;  // instruction word width

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_ADDR = 30'h0000_0000;

  // S_REQ  : fetch request on the bus for the current pc
  // S_WAIT : request accepted, waiting for the response beat
  // S_HOLD : instruction presented to decode until it is consumed
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/pc_fetch_perf.sv
// Purpose : fetch / stall event counters for the fetch sequencer.
// Latency : counters update one cycle after the qualifying event.
// Backpressure: none; free-running counters that wrap modulo 2^32.
//
// Ports:
//   clk, rst       : core clock, synchronous active-high reset
//   fetch_inc      : one instruction consumed by decode this cycle
//   stall_inc      : decode held the presented instruction this cycle
//   perf_fetch_cnt : consumed-instruction count
//   perf_stall_cnt : stall-cycle count
module pc_fetch_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (fetch_inc) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_inc) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Purpose : PC register and instruction-fetch sequencer (request/response imem port).
// Latency : zero-wait memory gives instr_valid one cycle after the request; 1 instr / 2 cycles.
// Backpressure: imem_ready/imem_rvalid stretch the fetch; stall holds the presented instruction.
//
// Ports:
//   clk, rst        : core clock, synchronous active-high reset
//   next_addr       : next word address from the next-PC logic (taken verbatim)
//   stall           : decode/hazard hold of the presented instruction
//   imem_req/addr   : fetch request and its word address
//   imem_ready      : memory accepts the request
//   imem_rvalid/rdata : response beat
//   cur_addr, instr, instr_valid : presented instruction and its PC
//   perf_fetch_cnt, perf_stall_cnt : only when PC_FETCH_PERF_EN is defined
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:2]        next_addr,
  input  logic               stall,
  output logic               imem_req,
  output logic [31:2]        imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [31:2]        cur_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  instr_q;
  logic                capture_en;
  logic                pc_load;

  // Response data is only meaningful while a request is in flight; rvalid
  // in S_REQ counts only together with ready (zero-wait memory).
  assign capture_en = ((state_q == S_REQ)  && imem_ready && imem_rvalid) ||
                      ((state_q == S_WAIT) && imem_rvalid);

  // Decode consumes the instruction: advance to the next-PC result.
  assign pc_load = (state_q == S_HOLD) && !stall;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_ready && imem_rvalid) state_d = S_HOLD;
        else if (imem_ready)           state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!stall) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // Outputs decode registered state only, so stall/next_addr never reach them.
  always_comb begin
    imem_req    = (state_q == S_REQ);
    instr_valid = (state_q == S_HOLD);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_ADDR;
      instr_q <= '0;
    end else begin
      if (pc_load)    pc      <= next_addr;
      if (capture_en) instr_q <= imem_rdata;
    end
  end

  assign imem_addr = pc;
  assign cur_addr  = pc;
  assign instr     = instr_q;

`ifdef PC_FETCH_PERF_EN
  pc_fetch_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_inc      (pc_load),
    .stall_inc      ((state_q == S_HOLD) && stall),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Purpose : directed self-checking bench for pc_fetch.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: bench plays the instruction memory and decode directly.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] next_addr;
  logic        stall;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [29:0] cur_addr;
  logic [31:0] instr;
  logic        instr_valid;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_ADDR(30'h0000_0000)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .next_addr   (next_addr),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .cur_addr    (cur_addr),
    .instr       (instr),
    .instr_valid (instr_valid)
`ifdef PC_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; next_addr = 30'h2A; idle_inputs();
    tick(); tick();
    rst = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got=%b exp=1", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (cur_addr !== 30'h0 || imem_addr !== 30'h0) begin errors++; $display("FAIL reset_addr got=%h/%h exp=0", cur_addr, imem_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr); end
  endtask

  task automatic test_zero_wait();
    // cycle 1: request at address 0
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h0) begin errors++; $display("FAIL zw_c1 got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005; next_addr = 30'h1;
    tick();
    idle_inputs();
    // cycle 2: instruction presented
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h2008_0005) begin errors++; $display("FAIL zw_c2 got v=%b instr=%h exp v=1 instr=20080005", instr_valid, instr); end
    checks++; if (imem_req !== 1'b0 || cur_addr !== 30'h0) begin errors++; $display("FAIL zw_c2_req got req=%b cur=%h exp req=0 cur=0", imem_req, cur_addr); end
    tick();
    // cycle 3: next request
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h1 || instr_valid !== 1'b0) begin errors++; $display("FAIL zw_c3 got req=%b addr=%h v=%b exp req=1 addr=1 v=0", imem_req, imem_addr, instr_valid); end
  endtask

  task automatic test_wait_states();
    // three cycles without ready; a stray rvalid without ready must be ignored
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h1) begin errors++; $display("FAIL ws_noready%0d got req=%b addr=%h exp req=1 addr=1", i, imem_req, imem_addr); end
      imem_ready = 1'b0; imem_rvalid = (i == 1); imem_rdata = 32'hBAD0_0000; next_addr = 30'h33;
      tick();
    end
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL ws_still_req got req=%b v=%b exp req=1 v=0", imem_req, instr_valid); end
    imem_ready = 1'b1; imem_rvalid = 1'b0;
    tick();
    imem_ready = 1'b0;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 30'h1) begin errors++; $display("FAIL ws_wait1 got req=%b v=%b addr=%h exp 0/0/1", imem_req, instr_valid, imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL ws_wait2 got req=%b v=%b exp 0/0", imem_req, instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h8C0A_0004;
    tick();
    idle_inputs();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C0A_0004 || cur_addr !== 30'h1) begin errors++; $display("FAIL ws_hold got v=%b instr=%h cur=%h exp 1/8c0a0004/1", instr_valid, instr, cur_addr); end
  endtask

  task automatic test_stall();
    logic [29:0] na [4];
    na[0] = 30'h5; na[1] = 30'h9; na[2] = 30'h2; na[3] = 30'h7;
    for (int i = 0; i < 4; i++) begin
      stall = 1'b1; next_addr = na[i];
      tick();
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C0A_0004 || cur_addr !== 30'h1 || imem_req !== 1'b0) begin errors++; $display("FAIL stall%0d got v=%b instr=%h cur=%h req=%b exp 1/8c0a0004/1/0", i, instr_valid, instr, cur_addr, imem_req); end
    end
    stall = 1'b0; next_addr = 30'h11;
    tick();
    next_addr = 30'h2;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h11) begin errors++; $display("FAIL stall_release got req=%b addr=%h exp req=1 addr=11", imem_req, imem_addr); end
  endtask

  task automatic fetch_zero_wait(input logic [31:0] data, input logic [29:0] nxt, input string tag);
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = data;
    tick();
    idle_inputs();
    checks++; if (instr_valid !== 1'b1 || instr !== data) begin errors++; $display("FAIL %s_hold got v=%b instr=%h exp v=1 instr=%h", tag, instr_valid, instr, data); end
    next_addr = nxt;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== nxt) begin errors++; $display("FAIL %s_addr got req=%b addr=%h exp req=1 addr=%h", tag, imem_req, imem_addr, nxt); end
  endtask

  task automatic test_jump_wrap();
    fetch_zero_wait(32'h0810_0008, 30'h0010_0008, "jump");
    fetch_zero_wait(32'h0BFF_FFFF, 30'h3FFF_FFFF, "top");
    fetch_zero_wait(32'h0000_0000, 30'h0000_0000, "wrap");
  endtask

  task automatic test_reset_midflight();
    next_addr = 30'h5;
    fetch_zero_wait(32'h2409_0001, 30'h0000_0040, "pre_rst");
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_wait got req=%b v=%b exp 0/0", imem_req, instr_valid); end
    rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; idle_inputs();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL mid_rst_instr got=%h exp=0", instr); end
    tick();
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_stay got req=%b v=%b exp 1/0", imem_req, instr_valid); end
  endtask

`ifdef PC_FETCH_PERF_EN
  task automatic test_perf();
    checks++; if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt); end
    for (int i = 0; i < 10; i++) begin
      imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1000 + i;
      tick();
      idle_inputs();
      if (i == 2 || i == 7) begin
        stall = 1'b1; tick();
        if (i == 7) tick();
        stall = 1'b0;
      end
      next_addr = 30'(i + 1);
      tick();
    end
    checks++; if (perf_fetch_cnt !== 32'd10) begin errors++; $display("FAIL perf_fetch got=%0d exp=10", perf_fetch_cnt); end
    checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall got=%0d exp=3", perf_stall_cnt); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_jump_wrap();
    test_reset_midflight();
`ifdef PC_FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
